// File: rtl/cache_pkg.sv
// Shared cache types plus the arbiter's state and requester-index types.
package cache_pkg;
    localparam int ADDR_WIDTH = 16;
    localparam int DATA_WIDTH = 32;
    localparam int OP_WIDTH   = 2;

    typedef logic [ADDR_WIDTH-1:0] UbitAddr;
    typedef logic [DATA_WIDTH-1:0] UbitData;

    typedef enum logic [OP_WIDTH-1:0] {
        Op_INVALID = 2'd0,
        Op_READ    = 2'd1,
        Op_WRITE   = 2'd2
    } Op;

    localparam int DEFAULT_NUM_REQ = 4;
    typedef logic [$clog2(DEFAULT_NUM_REQ)-1:0] UbitReqIdx;

    typedef enum logic [1:0] {
        ArbState_IDLE     = 2'd0,
        ArbState_ISSUE_WR = 2'd1,
        ArbState_WAIT_RD  = 2'd2
    } ArbState;
endpackage

// File: rtl/cache_arbiter_rr_picker.sv
// Combinational round-robin picker: first pending index strictly after last, wrapping.
module rr_picker #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  pending,
    input  logic [IW-1:0] last,
    output logic [IW-1:0] winner,
    output logic          any_pending
);
    logic [IW-1:0] cand;

    always_comb begin
        winner      = '0;
        any_pending = 1'b0;
        cand        = '0;
        for (int off = 1; off <= N; off++) begin
            cand = IW'((int'(last) + off) % N);
            if (!any_pending && pending[cand]) begin
                winner      = cand;
                any_pending = 1'b1;
            end
        end
    end
endmodule

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one cache port among NUM_REQ requesters, one op in flight.
// Optional read watchdog with timeout_err output when CACHE_ARB_TIMEOUT_EN is defined.
module cache_arbiter
    import cache_pkg::*;
#(
    parameter int NUM_REQ        = DEFAULT_NUM_REQ,
    parameter int IDX_WIDTH      = $clog2(NUM_REQ),
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ*OP_WIDTH-1:0]   cli_req_op,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] cli_req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] cli_req_data,
    output logic [NUM_REQ-1:0]            cli_gnt,
    output logic [NUM_REQ-1:0]            cli_rsp_vld,
    output logic [DATA_WIDTH-1:0]         cli_rsp_data,
    output logic [OP_WIDTH-1:0]           cache_req_op,
    output logic [ADDR_WIDTH-1:0]         cache_req_addr,
    output logic [DATA_WIDTH-1:0]         cache_req_data,
    input  logic                          cache_rsp_vld,
    input  logic [DATA_WIDTH-1:0]         cache_rsp_data,
    output logic                          busy,
    output logic [1:0]                    state_dbg
`ifdef CACHE_ARB_TIMEOUT_EN
    ,
    output logic                          timeout_err
`endif
);
    // Handshake: a requester holds op/addr/data (op != Op_INVALID acts as valid) until it
    // sees its cli_gnt pulse (ready), then drops to Op_INVALID on the next edge.
    ArbState                state, state_nxt;
    logic [IDX_WIDTH-1:0]   ptr, ptr_nxt, owner, owner_nxt, winner;
    logic                   any_pending;
    logic [NUM_REQ-1:0]     pending;
    logic [OP_WIDTH-1:0]    win_op, op_nxt;
    logic [ADDR_WIDTH-1:0]  win_addr, addr_nxt;
    logic [DATA_WIDTH-1:0]  win_data, data_nxt, rsp_data_nxt;
    logic [NUM_REQ-1:0]     gnt_nxt, rsp_vld_nxt;

`ifdef CACHE_ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
    logic          tmo_err_nxt;
`endif

    always_comb begin
        pending  = '0;
        win_op   = '0;
        win_addr = '0;
        win_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            pending[i] = (cli_req_op[i*OP_WIDTH +: OP_WIDTH] != Op_INVALID);
            if (winner == IDX_WIDTH'(i)) begin
                win_op   = cli_req_op[i*OP_WIDTH +: OP_WIDTH];
                win_addr = cli_req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                win_data = cli_req_data[i*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    rr_picker #(.N(NUM_REQ), .IW(IDX_WIDTH)) u_picker (
        .pending     (pending),
        .last        (ptr),
        .winner      (winner),
        .any_pending (any_pending)
    );

    always_comb begin
        state_nxt    = state;
        ptr_nxt      = ptr;
        owner_nxt    = owner;
        op_nxt       = Op_INVALID;
        addr_nxt     = cache_req_addr;
        data_nxt     = cache_req_data;
        gnt_nxt      = '0;
        rsp_vld_nxt  = '0;
        rsp_data_nxt = cli_rsp_data;
`ifdef CACHE_ARB_TIMEOUT_EN
        tmo_cnt_nxt  = tmo_cnt;
        tmo_err_nxt  = 1'b0;
`endif
        case (state)
            ArbState_IDLE: begin
                if (any_pending) begin
                    op_nxt           = win_op;
                    addr_nxt         = win_addr;
                    data_nxt         = win_data;
                    gnt_nxt[winner]  = 1'b1;
                    ptr_nxt          = winner;
                    owner_nxt        = winner;
                    state_nxt        = (win_op == Op_WRITE) ? ArbState_ISSUE_WR : ArbState_WAIT_RD;
`ifdef CACHE_ARB_TIMEOUT_EN
                    tmo_cnt_nxt      = '0;
`endif
                end
            end
            ArbState_ISSUE_WR: begin
                state_nxt = ArbState_IDLE;
            end
            ArbState_WAIT_RD: begin
                if (cache_rsp_vld) begin
                    rsp_data_nxt       = cache_rsp_data;
                    rsp_vld_nxt[owner] = 1'b1;
                    state_nxt          = ArbState_IDLE;
                end
`ifdef CACHE_ARB_TIMEOUT_EN
                // A real response in the same cycle as expiry wins over the watchdog.
                else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    rsp_data_nxt       = '0;
                    rsp_vld_nxt[owner] = 1'b1;
                    tmo_err_nxt        = 1'b1;
                    state_nxt          = ArbState_IDLE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
`endif
            end
            default: state_nxt = ArbState_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= ArbState_IDLE;
            ptr            <= IDX_WIDTH'(NUM_REQ - 1);
            owner          <= '0;
            cache_req_op   <= Op_INVALID;
            cache_req_addr <= '0;
            cache_req_data <= '0;
            cli_gnt        <= '0;
            cli_rsp_vld    <= '0;
            cli_rsp_data   <= '0;
`ifdef CACHE_ARB_TIMEOUT_EN
            tmo_cnt        <= '0;
            timeout_err    <= 1'b0;
`endif
        end else begin
            state          <= state_nxt;
            ptr            <= ptr_nxt;
            owner          <= owner_nxt;
            cache_req_op   <= op_nxt;
            cache_req_addr <= addr_nxt;
            cache_req_data <= data_nxt;
            cli_gnt        <= gnt_nxt;
            cli_rsp_vld    <= rsp_vld_nxt;
            cli_rsp_data   <= rsp_data_nxt;
`ifdef CACHE_ARB_TIMEOUT_EN
            tmo_cnt        <= tmo_cnt_nxt;
            timeout_err    <= tmo_err_nxt;
`endif
        end
    end

    assign busy      = (state != ArbState_IDLE);
    assign state_dbg = state;
endmodule
